// File: rtl/timer_pkg.sv
// timer_pkg: shared widths and reset constants for the up-counting timer
package timer_pkg;
  localparam int TIMER_W = 32;
  localparam int PRESC_W = 8;
  localparam logic [TIMER_W-1:0] CMP_RESET = '1;
endpackage

// File: rtl/up_timer_32bit_if.sv
// up_timer_32bit_if: timer control/status bundle; master drives en/load/ld_data/presc/cmp_we/cmp_data/irq_clr, slave returns Q/tick/match/irq/ovf
interface up_timer_32bit_if;
  import timer_pkg::*;
  logic en;
  logic load;
  logic [TIMER_W-1:0] ld_data;
  logic [PRESC_W-1:0] presc;
  logic cmp_we;
  logic [TIMER_W-1:0] cmp_data;
  logic irq_clr;
  logic [TIMER_W-1:0] Q;
  logic tick;
  logic match;
  logic irq;
  logic ovf;
  modport master (
    output en, load, ld_data, presc, cmp_we, cmp_data, irq_clr,
    input Q, tick, match, irq, ovf
  );
  modport slave (
    input en, load, ld_data, presc, cmp_we, cmp_data, irq_clr,
    output Q, tick, match, irq, ovf
  );
endinterface

// File: rtl/timer_prescaler.sv
// timer_prescaler: enabled-cycle divider; ports clk, rst_n, en, clr (load restart), presc (ratio-1), fire (increment strobe)
module timer_prescaler
  import timer_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] presc,
  output logic               fire
);
  logic [PRESC_W-1:0] pcnt;
  assign fire = en && (pcnt >= presc);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pcnt <= '0;
    else pcnt <= (clr || fire) ? '0 : en ? pcnt + 1'b1 : pcnt;
endmodule

// File: rtl/up_timer_32bit.sv
// up_timer_32bit: loadable prescaled up-counter with compare match and sticky irq/ovf; ports clk, rst_n (async low), bus (slave side of up_timer_32bit_if)
module up_timer_32bit
  import timer_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  up_timer_32bit_if.slave bus
);
  logic fire, inc, upd, hit, wrap;
  logic [TIMER_W-1:0] cmp, q_nxt;
  timer_prescaler u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.en),
    .clr   (bus.load),
    .presc (bus.presc),
    .fire  (fire)
  );
  always_comb begin
    inc   = fire && !bus.load;
    upd   = inc || bus.load;
    q_nxt = bus.load ? bus.ld_data : inc ? bus.Q + 1'b1 : bus.Q;
    hit   = upd && (q_nxt == cmp);
    wrap  = inc && (&bus.Q);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.Q     <= '0;
      cmp       <= CMP_RESET;
      bus.tick  <= 1'b0;
      bus.match <= 1'b0;
      bus.irq   <= 1'b0;
      bus.ovf   <= 1'b0;
    end else begin
      bus.Q     <= q_nxt;
      cmp       <= bus.cmp_we ? bus.cmp_data : cmp;
      bus.tick  <= inc;
      bus.match <= hit;
      bus.irq   <= hit || (bus.irq && !bus.irq_clr);
      bus.ovf   <= wrap || (bus.ovf && !bus.irq_clr);
    end
endmodule

// File: tb/tb_up_timer_32bit.sv
// tb_up_timer_32bit: scoreboard bench with a behavioural timer model, directed scenarios and random traffic
module tb_up_timer_32bit;
  import timer_pkg::*;
  typedef struct packed {
    logic [31:0] q;
    logic tick;
    logic match;
    logic irq;
    logic ovf;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  up_timer_32bit_if bus();
  up_timer_32bit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  longint m_q, m_cmp;
  int m_pc;
  bit m_irq, m_ovf;
  int pr_r;
  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_q = 0;
    m_cmp = 64'hFFFF_FFFF;
    m_pc = 0;
    m_irq = 0;
    m_ovf = 0;
  endtask
  task automatic idle_inputs();
    bus.en = 0; bus.load = 0; bus.ld_data = '0; bus.presc = '0;
    bus.cmp_we = 0; bus.cmp_data = '0; bus.irq_clr = 0;
  endtask
  task automatic step(input bit en, input bit ld, input logic [31:0] ldd, input int pr,
                      input bit cw, input logic [31:0] cd, input bit clr);
    bit tk, mt, upd, wrap;
    exp_t e;
    @(negedge clk);
    bus.en = en; bus.load = ld; bus.ld_data = ldd; bus.presc = 8'(pr);
    bus.cmp_we = cw; bus.cmp_data = cd; bus.irq_clr = clr;
    tk = 0; upd = 0; wrap = 0;
    if (ld) begin
      m_q = ldd;
      m_pc = 0;
      upd = 1;
    end else if (en) begin
      if (m_pc >= pr) begin
        m_pc = 0;
        m_q = (m_q + 1) % (64'd1 << 32);
        tk = 1;
        upd = 1;
        wrap = (m_q == 0);
      end else m_pc++;
    end
    mt = upd && (m_q == m_cmp);
    m_irq = mt || (m_irq && !clr);
    m_ovf = wrap || (m_ovf && !clr);
    if (cw) m_cmp = cd;
    e.q = m_q[31:0]; e.tick = tk; e.match = mt; e.irq = m_irq; e.ovf = m_ovf;
    sb.push_back(e);
  endtask
  task automatic check_reset_values(input string tag);
    chk({tag, "_Q"}, bus.Q, 0);
    chk({tag, "_tick"}, bus.tick, 0);
    chk({tag, "_match"}, bus.match, 0);
    chk({tag, "_irq"}, bus.irq, 0);
    chk({tag, "_ovf"}, bus.ovf, 0);
  endtask
  task automatic reset_mid();
    @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    check_reset_values("async_rst");
    model_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
  endtask
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("Q", bus.Q, e.q);
      chk("tick", bus.tick, e.tick);
      chk("match", bus.match, e.match);
      chk("irq", bus.irq, e.irq);
      chk("ovf", bus.ovf, e.ovf);
    end
  end
  initial begin
    idle_inputs();
    model_reset();
    #2;
    check_reset_values("init_rst");
    @(negedge clk);
    rst_n = 1;
    repeat (5) step(1, 0, 0, 0, 0, 0, 0);
    reset_mid();
    repeat (6) step(1, 0, 0, 3, 0, 0, 0);
    repeat (2) step(0, 0, 0, 3, 0, 0, 0);
    repeat (8) step(1, 0, 0, 3, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'd10, 0);
    step(0, 1, 32'd7, 0, 0, 0, 0);
    repeat (5) step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 32'd9, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 32'hFFFF_FFFE, 0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10 && m_pc != 2; i++) step(1, 0, 0, 2, 0, 0, 0);
    step(1, 1, 32'h100, 2, 0, 0, 0);
    repeat (4) step(1, 0, 0, 2, 0, 0, 0);
    step(0, 1, 32'd20, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'd20, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'd20, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    pr_r = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ldd, cd;
      int r;
      if ($urandom_range(0, 9) == 0) pr_r = $urandom_range(0, 4);
      r = $urandom_range(0, 3);
      ldd = (r == 0) ? $urandom : (r == 1) ? 32'hFFFF_FFFF - $urandom_range(0, 3) :
            (r == 2) ? 32'(m_cmp) - $urandom_range(0, 3) : $urandom_range(0, 50);
      cd = 32'(m_q) + $urandom_range(0, 6);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, ldd, pr_r,
           $urandom_range(0, 19) == 0, cd, $urandom_range(0, 11) == 0);
      if (i == 1500) reset_mid();
    end
    @(posedge clk);
    #2;
    chk("drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/up_timer_32bit.md
# up_timer_32bit

Synchronous, loadable 32-bit up-counting timer with programmable prescaler, compare match and sticky overflow/interrupt flags. It complements the existing down counter: where that block counts down, this one counts up from a loadable value and raises an interrupt when a compare value is reached. It sits beside the core as the machine-timer source (mtime/mtimecmp-style) and drives the interrupt line into the CSR/trap logic.

## Interface
- WIDTH, 32, counter and compare width
- PRESC_W, 8, prescaler ratio width
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  count enable; gates prescaler advance
- load  in  1  synchronous load of ld_data into Q
- ld_data  in  WIDTH  load value
- presc  in  PRESC_W  divide ratio; Q advances once per presc+1 enabled cycles
- cmp_we  in  1  write compare register
- cmp_data  in  WIDTH  compare value
- irq_clr  in  1  clear irq and ovf
- Q  out  WIDTH  current count
- tick  out  1  one-cycle pulse, high in the cycle Q shows an incremented value
- match  out  1  one-cycle pulse, high in the first cycle Q equals compare after a Q update
- irq  out  1  sticky level, set by match
- ovf  out  1  sticky level, set by wrap from all-ones to zero

## Operation
- Reset (rst_n low, async): Q=0, cmp=all-ones, prescaler count pcnt=0, tick=0, match=0, irq=0, ovf=0.
- Prescaler: en high and pcnt>=presc -> pcnt<=0, increment fires; en high otherwise -> pcnt<=pcnt+1; en low -> pcnt holds, no increment.
- pcnt>=presc comparison (not ==): presc lowered below pcnt mid-count fires on next enabled cycle.
- Increment: Q<=Q+1, modulo 2^WIDTH; from all-ones wraps to 0 and sets ovf.
- Load: Q<=ld_data, pcnt<=0; load has priority over a same-cycle increment (no increment, no tick, no ovf).
- Compare: cmp_we -> cmp<=cmp_data next edge. Match evaluated on next-Q only when Q is updated (increment or load); writing cmp equal to current Q does not produce match.
- Compare uses the cmp value in effect before the edge (cmp_we same cycle as update: old cmp used).
- match sets irq. irq_clr clears irq and ovf; same-cycle set and clr: set wins.
- tick and match are registered; never high two consecutive cycles unless presc=0 and Q advances/matches every cycle (tick only).

## Timing
- presc=0, en held high: Q increments every edge; first increment on first edge with en sampled high.
- presc=N: increments spaced N+1 enabled cycles; en low stretches spacing by the number of low cycles.
- Load latency 1 cycle: Q=ld_data in the cycle after load sampled.
- match, irq, tick, ovf valid in the same cycle as the corresponding Q value (all registered on the same edge).
- irq/ovf fall 1 cycle after irq_clr sampled.
- Reset mid-count: all outputs return to reset values immediately, independent of clk.

## Structure
- Package timer_pkg: TIMER_W=32, PRESC_W=8, CMP_RESET=all-ones.
- One sub-module: timer_prescaler (pcnt register, >= compare, en gating, sync clear from load; outputs fire strobe).
- Top: Q register, cmp register, next-Q mux (load > increment > hold), equality compare, tick/match/irq/ovf registers.

## Test plan
- Reset then en=1, presc=0 for 5 cycles -> Q=1,2,3,4,5, tick high every cycle, irq=0, ovf=0; assert rst_n low mid-run -> Q=0 immediately.
- presc=3, en=1 -> Q increments every 4th cycle; drop en for 2 cycles mid-period -> next increment delayed by exactly 2 cycles.
- cmp=10, load Q=7, presc=0 -> match pulse single cycle when Q=10, irq stays 1 afterwards; irq_clr -> irq=0 next cycle; irq_clr same cycle as new match -> irq stays 1.
- load 0xFFFFFFFE, presc=0 -> Q=0xFFFFFFFF, then 0x00000000 with ovf=1; irq_clr -> ovf=0.
- load and increment strobe in same cycle with ld_data=0x100 -> Q=0x100, no tick, pcnt restarts (next increment after presc+1 cycles).
- Q=20 held (en=0), cmp_we with cmp_data=20 -> no match; load ld_data=20 -> match pulse, irq=1.
